// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 width encodings,
// controller FSM states and the access-size decode used by lane steering.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_e;

    // Reserved encodings (011, 110, 111) fall through to a full word.
    function automatic lsu_size_e f3_size(input logic [2:0] f3);
        case (f3)
            F3_LB, F3_LBU: f3_size = SZ_B;
            F3_LH, F3_LHU: f3_size = SZ_H;
            default:       f3_size = SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load alignment: shifts the memory word down by the byte
// offset and sign/zero-extends according to funct3. Shared with future caches.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] shifted;

    assign shifted = rdata >> {offset, 3'b000};

    always_comb begin
        data = shifted;
        case (funct3)
            F3_LB:   data = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   data = {{16{shifted[15]}}, shifted[15:0]};
            F3_LBU:  data = {24'h000000, shifted[7:0]};
            F3_LHU:  data = {16'h0000, shifted[15:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// MEM-stage load/store controller: one access per request, stalls the pipeline
// until mem_ack. Optional misalignment trap enabled by LSU_MISALIGN_TRAP_EN.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    input  logic                req_we,
    input  logic [2:0]          req_funct3,
    input  logic [DATA_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                lsu_stall,
    output logic                load_valid,
    output logic [DATA_W-1:0]   load_data,
    output logic                misalign_err,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W-1:0]   mem_addr,
    output logic [DATA_W/8-1:0] mem_wstrb,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata
);

    lsu_state_e        state_reg, state_next;
    logic              we_reg;
    logic [2:0]        funct3_reg;
    logic [1:0]        off_reg;
    logic              mis_reg;
    logic [DATA_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [3:0]        wstrb_reg;
    logic [DATA_W-1:0] load_data_reg;

    lsu_size_e         req_size;
    logic [1:0]        req_off;
    logic [3:0]        req_wstrb;
    logic [DATA_W-1:0] req_lanes;
    logic              req_mis;
    logic              accept;
    logic [DATA_W-1:0] align_data;

    assign accept = (state_reg == IDLE) && req_valid;

    // Offset is truncated to natural alignment so an untrapped misaligned
    // access still lands on a legal lane.
    always_comb begin
        req_size  = f3_size(req_funct3);
        req_off   = 2'b00;
        req_wstrb = 4'b1111;
        req_lanes = req_wdata;
        case (req_size)
            SZ_B: begin
                req_off   = req_addr[1:0];
                req_wstrb = 4'b0001 << req_addr[1:0];
                req_lanes = {4{req_wdata[7:0]}};
            end
            SZ_H: begin
                req_off   = {req_addr[1], 1'b0};
                req_wstrb = 4'b0011 << {req_addr[1], 1'b0};
                req_lanes = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
        if (!req_we) begin
            req_wstrb = 4'b0000;
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_mis = ((req_size == SZ_H) && req_addr[0]) ||
                     ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));
`else
    assign req_mis = 1'b0;
`endif

    lsu_load_align u_load_align (
        .rdata  (mem_rdata),
        .offset (off_reg),
        .funct3 (funct3_reg),
        .data   (align_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            we_reg        <= 1'b0;
            funct3_reg    <= 3'b000;
            off_reg       <= 2'b00;
            mis_reg       <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            wstrb_reg     <= 4'b0000;
            load_data_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                we_reg     <= req_we;
                funct3_reg <= req_funct3;
                off_reg    <= req_off;
                mis_reg    <= req_mis;
                addr_reg   <= {req_addr[DATA_W-1:2], 2'b00};
                wdata_reg  <= req_lanes;
                wstrb_reg  <= req_wstrb;
            end
            if ((state_reg == BUSY) && mem_ack && !we_reg) begin
                load_data_reg <= align_data;
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        mem_req      = 1'b0;
        lsu_stall    = 1'b0;
        load_valid   = 1'b0;
        misalign_err = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    lsu_stall  = 1'b1;
                    state_next = req_mis ? DONE : BUSY;
                end
            end
            BUSY: begin
                mem_req   = 1'b1;
                lsu_stall = 1'b1;
                if (mem_ack) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                load_valid = !we_reg && !mis_reg;
`ifdef LSU_MISALIGN_TRAP_EN
                misalign_err = mis_reg;
`endif
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign mem_we    = we_reg;
    assign mem_addr  = addr_reg;
    assign mem_wstrb = wstrb_reg;
    assign mem_wdata = wdata_reg;
    assign load_data = load_data_reg;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed vector table, reset corner
// case and randomized accesses checked against a byte-lane arithmetic model.
module tb_lsu_mem_ctrl;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        lsu_stall;
    logic        load_valid;
    logic [31:0] load_data;
    logic        misalign_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .lsu_stall    (lsu_stall),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .misalign_err (misalign_err),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wstrb    (mem_wstrb),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata)
    );

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
        logic        mis;
        logic [31:0] exp_addr;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata;
        logic [31:0] exp_ld;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic we, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input int delay, input logic mis,
                                input logic [31:0] exp_addr, input logic [3:0] exp_strb,
                                input logic [31:0] exp_wdata, input logic [31:0] exp_ld);
        vec_t v;
        v.name = name; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.rdata = rdata; v.delay = delay; v.mis = mis; v.exp_addr = exp_addr;
        v.exp_strb = exp_strb; v.exp_wdata = exp_wdata; v.exp_ld = exp_ld;
        return v;
    endfunction

    // Reference model: access size in bytes, aligned-down offset, lane math.
    function automatic vec_t model(input string name, input logic we, input logic [2:0] f3,
                                   input logic [31:0] addr, input logic [31:0] wdata,
                                   input logic [31:0] rdata, input int delay);
        int unsigned sz, off, bits;
        logic [31:0] w, mask;
        vec_t v;
        sz = (f3 == 3'b000 || f3 == 3'b100) ? 1 : (f3 == 3'b001 || f3 == 3'b101) ? 2 : 4;
        off = int'(addr[1:0]) - (int'(addr[1:0]) % sz);
        v.name = name; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.rdata = rdata; v.delay = delay;
        v.mis = TRAP && ((sz == 2 && addr[0]) || (sz == 4 && addr[1:0] != 2'b00));
        v.exp_addr = addr & 32'hFFFF_FFFC;
        v.exp_strb = we ? 4'(((1 << sz) - 1) << off) : 4'b0000;
        if (sz == 1)      v.exp_wdata = {24'h0, wdata[7:0]} * 32'h0101_0101;
        else if (sz == 2) v.exp_wdata = {16'h0, wdata[15:0]} * 32'h0001_0001;
        else              v.exp_wdata = wdata;
        w = rdata >> (8 * off);
        if (sz == 4) begin
            v.exp_ld = w;
        end else begin
            bits = 8 * sz;
            mask = (32'h1 << bits) - 32'h1;
            v.exp_ld = w & mask;
            if (!f3[2] && w[bits-1]) v.exp_ld = v.exp_ld | ~mask;
        end
        return v;
    endfunction

    task automatic run_access(input vec_t v);
        int busy;
        int stalls;
        @(negedge clk);
        req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3;
        req_addr = v.addr; req_wdata = v.wdata; mem_ack = 1'b0;
        #1;
        check({v.name, ":stall_accept"}, 32'(lsu_stall), 32'd1);
        check({v.name, ":req_accept"}, 32'(mem_req), 32'd0);
        stalls = 1;
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        #1;
        if (v.mis) begin
            check({v.name, ":misalign_pulse"}, 32'(misalign_err), 32'd1);
            check({v.name, ":mis_no_req"}, 32'(mem_req), 32'd0);
            check({v.name, ":mis_stall"}, 32'(lsu_stall), 32'd0);
            check({v.name, ":mis_no_valid"}, 32'(load_valid), 32'd0);
            @(negedge clk);
            #1;
            check({v.name, ":mis_pulse_end"}, 32'(misalign_err), 32'd0);
            check({v.name, ":mis_idle_req"}, 32'(mem_req), 32'd0);
            $display("txn %s we=%0d f3=%0d addr=%h trapped", v.name, v.we, v.f3, v.addr);
            return;
        end
        busy = 0;
        while (mem_req === 1'b1 && busy <= v.delay) begin
            if (lsu_stall === 1'b1) stalls++;
            check({v.name, ":mem_we"}, 32'(mem_we), 32'(v.we));
            check({v.name, ":mem_addr"}, mem_addr, v.exp_addr);
            check({v.name, ":mem_wstrb"}, 32'(mem_wstrb), 32'(v.exp_strb));
            if (v.we) check({v.name, ":mem_wdata"}, mem_wdata, v.exp_wdata);
            check({v.name, ":misalign_busy"}, 32'(misalign_err), 32'd0);
            if (busy == v.delay) begin
                mem_ack = 1'b1; mem_rdata = v.rdata;
            end else begin
                mem_ack = 1'b0; mem_rdata = $urandom;
            end
            busy++;
            @(negedge clk);
            // Ack with garbage outside BUSY and a request in DONE: both must be ignored.
            mem_ack = 1'b1; mem_rdata = ~v.rdata; req_valid = 1'b1;
            #1;
        end
        check({v.name, ":busy_cycles"}, 32'(busy), 32'(v.delay + 1));
        check({v.name, ":done_req"}, 32'(mem_req), 32'd0);
        check({v.name, ":done_stall"}, 32'(lsu_stall), 32'd0);
        check({v.name, ":stall_cycles"}, 32'(stalls), 32'(v.delay + 2));
        check({v.name, ":load_valid"}, 32'(load_valid), 32'(!v.we));
        check({v.name, ":misalign_done"}, 32'(misalign_err), 32'd0);
        if (!v.we) check({v.name, ":load_data"}, load_data, v.exp_ld);
        @(negedge clk);
        req_valid = 1'b0; mem_ack = 1'b0;
        #1;
        check({v.name, ":no_accept_in_done"}, 32'(mem_req), 32'd0);
        check({v.name, ":valid_pulse_end"}, 32'(load_valid), 32'd0);
        if (!v.we) check({v.name, ":load_data_hold"}, load_data, v.exp_ld);
        $display("txn %s we=%0d f3=%0d addr=%h wdata=%h rdata=%h delay=%0d load_data=%h",
                 v.name, v.we, v.f3, v.addr, v.wdata, v.rdata, v.delay, load_data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[11];
        vec_t rv;
        logic        r_we;
        logic [2:0]  r_f3;

        tbl[0]  = mk("sw_100", 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, 32'h100, 4'hF, 32'hDEADBEEF, 32'h0);
        tbl[1]  = mk("sb_103", 1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 1, 0, 32'h100, 4'h8, 32'hA5A5A5A5, 32'h0);
        tbl[2]  = mk("lb_102", 0, 3'b000, 32'h102, 32'h0, 32'h12F03456, 0, 0, 32'h100, 4'h0, 32'h0, 32'hFFFFFFF0);
        tbl[3]  = mk("lbu_102", 0, 3'b100, 32'h102, 32'h0, 32'h12F03456, 2, 0, 32'h100, 4'h0, 32'h0, 32'h000000F0);
        tbl[4]  = mk("lh_100_d3", 0, 3'b001, 32'h100, 32'h0, 32'h00008001, 3, 0, 32'h100, 4'h0, 32'h0, 32'hFFFF8001);
        tbl[5]  = mk("lw_101", 0, 3'b010, 32'h101, 32'h0, 32'hCAFEF00D, 0, TRAP, 32'h100, 4'h0, 32'h0, 32'hCAFEF00D);
        tbl[6]  = mk("sh_102", 1, 3'b001, 32'h102, 32'h1234BEEF, 32'h0, 0, 0, 32'h100, 4'hC, 32'hBEEFBEEF, 32'h0);
        tbl[7]  = mk("lhu_102", 0, 3'b101, 32'h102, 32'h0, 32'h8001ABCD, 1, 0, 32'h100, 4'h0, 32'h0, 32'h00008001);
        tbl[8]  = mk("f3_011_104", 0, 3'b011, 32'h104, 32'h0, 32'h11223344, 0, 0, 32'h104, 4'h0, 32'h0, 32'h11223344);
        tbl[9]  = mk("lh_103", 0, 3'b001, 32'h103, 32'h0, 32'h8001ABCD, 0, TRAP, 32'h100, 4'h0, 32'h0, 32'hFFFF8001);
        tbl[10] = mk("sb_101", 1, 3'b000, 32'h101, 32'h0000007E, 32'h0, 0, 0, 32'h100, 4'h2, 32'h7E7E7E7E, 32'h0);

        repeat (2) @(negedge clk);
        #1;
        check("reset:stall", 32'(lsu_stall), 32'd0);
        check("reset:mem_req", 32'(mem_req), 32'd0);
        check("reset:load_valid", 32'(load_valid), 32'd0);
        check("reset:misalign", 32'(misalign_err), 32'd0);
        check("reset:load_data", load_data, 32'h0);
        check("reset:mem_addr", mem_addr, 32'h0);
        check("reset:mem_wstrb", 32'(mem_wstrb), 32'h0);
        check("reset:mem_wdata", mem_wdata, 32'h0);
        check("reset:mem_we", 32'(mem_we), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            run_access(tbl[i]);
        end

        // Reset asserted while the access is waiting in BUSY.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h200;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check("rst_mid:busy_req", 32'(mem_req), 32'd1);
        @(negedge clk);
        mem_ack = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_mid:mem_req_drop", 32'(mem_req), 32'd0);
        check("rst_mid:stall_drop", 32'(lsu_stall), 32'd0);
        check("rst_mid:load_valid", 32'(load_valid), 32'd0);
        $display("txn rst_mid lw addr=00000200 abandoned by reset");
        @(negedge clk);
        rst_n = 1'b1;
        run_access(mk("lw_after_rst", 0, 3'b010, 32'h208, 32'h0, 32'h5A5AC3C3, 1, 0, 32'h208, 4'h0, 32'h0, 32'h5A5AC3C3));

        for (int i = 0; i < 40; i++) begin
            r_we = 1'($urandom);
            r_f3 = r_we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            rv = model($sformatf("rand%0d", i), r_we, r_f3, $urandom, $urandom, $urandom,
                       int'($urandom_range(0, 3)));
            run_access(rv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
